// File: rtl/uart_tx_fifo_drain_if.sv
// FIFO read side and serial line of the TX drain serializer, bundled as one port.
// No storage; pure connectivity.
// The serializer owns the pop strobe; the FIFO owns empty/head-word.
interface uart_tx_fifo_drain_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  fifo_rd_en;
    logic                  tx;
    logic                  busy;
    logic                  tx_done;

    // serializer side: consumes the FIFO head, drives the line and status
    modport master (
        input  fifo_empty, fifo_dout,
        output fifo_rd_en, tx, busy, tx_done
    );

    // FIFO / line side
    modport slave (
        output fifo_empty, fifo_dout,
        input  fifo_rd_en, tx, busy, tx_done
    );
endinterface

// File: rtl/uart_tx_fifo_drain.sv
// UART TX serializer draining a show-ahead FIFO: start, LSB-first data, optional parity, stop bit(s).
// Latency: start bit and pop strobe appear one clk after fifo_empty is seen low; frames run back to back.
// Backpressure: only pops when a frame can start immediately; the FIFO head is held off by not popping.
module uart_tx_fifo_drain #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                clk,
    input  logic                reset,
    uart_tx_fifo_drain_if.master bus
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_WIDTH) + 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_WIDTH - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
    localparam logic             PAR_ODD   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;     // data bit index, reused to count stop bits
    logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
    logic                    par_q, par_d;
    logic                    tx_q, tx_d;
    logic                    busy_q, busy_d;
    logic                    rd_en_q, rd_en_d;
    logic                    done_q, done_d;
    logic                    bit_end;
    logic                    load;

    // Next-state: baud counting, bit sequencing and the word load / pop on frame start.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        rd_en_d = 1'b0;
        done_d  = 1'b0;
        load    = 1'b0;
        bit_end = (cnt_q == CNT_LAST);

        if (state_q != IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                load = !bus.fifo_empty;
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    idx_d   = '0;
                    tx_d    = shreg_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == DATA_LAST) begin
                        if (PARITY_EN != 0) begin
                            state_d = PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = STOP;
                            idx_d   = '0;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        shreg_d = shreg_q >> 1;
                        tx_d    = shreg_d[0];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    idx_d   = '0;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (idx_q == STOP_LAST) begin
                        done_d = 1'b1;
                        if (!bus.fifo_empty) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                            idx_d   = '0;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        // Frame start: the head word is valid now, so capture it and pop it next cycle.
        if (load) begin
            state_d = START;
            cnt_d   = '0;
            idx_d   = '0;
            shreg_d = bus.fifo_dout;
            par_d   = (^bus.fifo_dout) ^ PAR_ODD;
            rd_en_d = 1'b1;
            tx_d    = 1'b0;
            busy_d  = 1'b1;
        end
    end

    // State and output registers; reset drops any frame in flight and returns the line high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            rd_en_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            rd_en_q <= rd_en_d;
            done_q  <= done_d;
        end
    end

    assign bus.tx         = tx_q;
    assign bus.busy       = busy_q;
    assign bus.fifo_rd_en = rd_en_q;
    assign bus.tx_done    = done_q;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Three serializer configurations driven from queue-model FIFOs with random traffic.
// A per-lane receiver decodes the line and compares each frame with the word pushed.
// Reset mid-frame and a long idle stretch are exercised at the end.
module tb_uart_tx_fifo_drain;

    logic clk;
    logic rst_n;
    bit   go;
    int   quota [3];
    int   errors;
    int   checks;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input bit ok, input string name, input int act, input int exp_v);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : lane
        // lane 0: 8N1, 4 clk/bit; lane 1: 8E2, 3 clk/bit; lane 2: 7O1, 5 clk/bit
        localparam int DW  = (g == 2) ? 7 : 8;
        localparam int CPB = (g == 0) ? 4 : (g == 1) ? 3 : 5;
        localparam int PE  = (g == 0) ? 0 : 1;
        localparam int PO  = (g == 2) ? 1 : 0;
        localparam int SB  = (g == 1) ? 2 : 1;
        localparam int NB  = 1 + DW + PE + SB;

        logic [DW-1:0] fq[$];
        logic [DW-1:0] exp_q[$];
        int  sent;
        bit  drained;
        bit  in_frame;
        int  cur_bit;
        int  aborts;
        int  b2b;

        uart_tx_fifo_drain_if #(.DATA_WIDTH(DW)) bus ();

        uart_tx_fifo_drain #(
            .DATA_WIDTH  (DW),
            .CLKS_PER_BIT(CPB),
            .PARITY_EN   (PE),
            .PARITY_ODD  (PO),
            .STOP_BITS   (SB)
        ) dut (
            .clk  (clk),
            .reset(rst_n),
            .bus  (bus)
        );

        // Expected line levels of one frame, index 0 = start bit.
        function automatic logic [NB-1:0] frame_bits(input logic [DW-1:0] w);
            logic [NB-1:0] f;
            f    = '1;
            f[0] = 1'b0;
            for (int i = 0; i < DW; i++) f[i+1] = w[i];
            if (PE != 0) f[DW+1] = 1'(($countones(w) + PO) % 2);
            return f;
        endfunction

        // FIFO model and stimulus: pops on rd_en, pushes directed then random words.
        initial begin : stim
            int dq[$];
            int head;
            bit rd_prev;
            logic [DW-1:0] w;
            sent = 0; drained = 1'b0; rd_prev = 1'b0;
            if (g == 0)      dq = '{32'h1_00A5, 32'h1_0000, 32'h0_00FF};
            else if (g == 1) dq = '{32'h1_0007, 32'h1_0055};
            else             dq = '{32'h1_0007};
            bus.fifo_empty = 1'b1;
            bus.fifo_dout  = '0;
            forever begin
                @(negedge clk);
                #1;
                if (bus.fifo_rd_en) begin
                    check(fq.size() != 0 && !rd_prev, "pop_legal", fq.size(), 1);
                    if (fq.size() != 0) void'(fq.pop_front());
                end
                rd_prev = bus.fifo_rd_en;
                if (go && sent < quota[g]) begin
                    if (dq.size() != 0) begin
                        head = dq[0];
                        if (head[16] == 1'b0 || (fq.size() == 0 && !bus.busy && !in_frame)) begin
                            w = DW'(dq.pop_front());
                            fq.push_back(w);
                            exp_q.push_back(w);
                            sent++;
                        end
                    end else if ($urandom_range(0, 47) == 0 && fq.size() < 4) begin
                        w = DW'($urandom);
                        fq.push_back(w);
                        exp_q.push_back(w);
                        sent++;
                    end
                end
                bus.fifo_empty = (fq.size() == 0);
                bus.fifo_dout  = (fq.size() == 0) ? DW'($urandom) : fq[0];
                drained = (sent == quota[g]) && (fq.size() == 0) && (exp_q.size() == 0) && !in_frame;
            end
        end

        // Line receiver: checks each frame bit-for-bit, the pop pulse, busy and tx_done.
        initial begin : mon
            logic [NB-1:0] expb, obs, unst;
            logic [DW-1:0] w;
            bit rd_ok, busy_ok, done_ok, aborted;
            in_frame = 1'b0; cur_bit = -1; aborts = 0; b2b = 0;
            @(negedge clk);
            forever begin
                if (!rst_n) begin
                    check({bus.tx, bus.busy, bus.fifo_rd_en, bus.tx_done} == 4'b1000, "reset_outputs",
                          int'({bus.tx, bus.busy, bus.fifo_rd_en, bus.tx_done}), 8);
                    @(negedge clk);
                end else if (bus.tx) begin
                    check({bus.busy, bus.fifo_rd_en, bus.tx_done} == 3'b000, "idle_outputs",
                          int'({bus.busy, bus.fifo_rd_en, bus.tx_done}), 0);
                    check(bus.fifo_empty == 1'b1, "start_latency", int'(bus.tx), 0);
                    @(negedge clk);
                end else begin
                    in_frame = 1'b1;
                    check(exp_q.size() != 0, "frame_expected", exp_q.size(), 1);
                    w = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                    expb = frame_bits(w);
                    obs = '0; unst = '0;
                    rd_ok = 1'b1; busy_ok = 1'b1; done_ok = 1'b1; aborted = 1'b0;
                    for (int k = 0; k < NB && !aborted; k++) begin
                        cur_bit = k;
                        for (int c = 0; c < CPB && !aborted; c++) begin
                            if (k != 0 || c != 0) @(negedge clk);
                            if (!rst_n) begin
                                aborted = 1'b1;
                            end else begin
                                if (c == 0) obs[k] = bus.tx;
                                else if (bus.tx !== obs[k]) unst[k] = 1'b1;
                                if (bus.fifo_rd_en !== (k == 0 && c == 0)) rd_ok = 1'b0;
                                if (bus.busy !== 1'b1) busy_ok = 1'b0;
                                if ((k != 0 || c != 0) && bus.tx_done !== 1'b0) done_ok = 1'b0;
                            end
                        end
                    end
                    cur_bit = -1;
                    if (aborted) begin
                        aborts++;
                        in_frame = 1'b0;
                    end else begin
                        check(obs == expb, "frame_bits", int'(obs), int'(expb));
                        check(unst == '0, "bit_time", int'(unst), 0);
                        check(rd_ok, "rd_en_pulse", int'(rd_ok), 1);
                        check(busy_ok, "busy_in_frame", int'(busy_ok), 1);
                        check(done_ok, "tx_done_early", int'(done_ok), 1);
                        @(negedge clk);
                        in_frame = 1'b0;
                        if (rst_n) begin
                            check(bus.tx_done == 1'b1, "tx_done_pulse", int'(bus.tx_done), 1);
                            check(bus.tx == bus.fifo_empty, "restart", int'(bus.tx), int'(bus.fifo_empty));
                            if (!bus.tx) begin
                                check(bus.busy == 1'b1, "busy_b2b", int'(bus.busy), 1);
                                b2b++;
                            end else begin
                                check(bus.busy == 1'b0, "busy_release", int'(bus.busy), 0);
                                @(negedge clk);
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        int t;
        errors = 0; checks = 0;
        rst_n = 1'b0; go = 1'b0;
        for (int i = 0; i < 3; i++) quota[i] = 30;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b1;
        go = 1'b1;

        t = 0;
        while (!(lane[0].drained && lane[1].drained && lane[2].drained) && t < 40000) begin
            @(posedge clk);
            t++;
        end
        check(t < 40000, "traffic_drain", t, 40000);

        // one more word on lane 0, reset during data bit 3
        quota[0] = quota[0] + 1;
        t = 0;
        while (lane[0].cur_bit != 4 && t < 5000) begin
            @(posedge clk);
            t++;
        end
        check(t < 5000, "reset_frame_start", t, 5000);
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (30) @(posedge clk);
        check(lane[0].aborts == 1, "frame_aborted", lane[0].aborts, 1);

        // quiet line with an empty FIFO
        repeat (1000) @(posedge clk);
        check(lane[0].drained && lane[1].drained && lane[2].drained, "final_drain",
              int'({lane[2].drained, lane[1].drained, lane[0].drained}), 7);
        check(lane[0].b2b > 0, "back_to_back_seen", lane[0].b2b, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
